// File: rtl/intersection_pkg.sv
// Shared phase codes, default timings and lamp decode for the intersection scheduler.
package intersection_pkg;

    localparam logic [2:0] NS_G  = 3'd0;
    localparam logic [2:0] NS_Y  = 3'd1;
    localparam logic [2:0] AR_NS = 3'd2;
    localparam logic [2:0] EW_G  = 3'd3;
    localparam logic [2:0] EW_Y  = 3'd4;
    localparam logic [2:0] AR_EW = 3'd5;
    localparam logic [2:0] PED   = 3'd6;

    localparam int DEF_MIN_GREEN = 8;
    localparam int DEF_MAX_GREEN = 20;
    localparam int DEF_YELLOW    = 3;
    localparam int DEF_ALL_RED   = 2;
    localparam int DEF_WALK      = 6;
    localparam int DEF_CW        = 5;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
        logic walk;
    } lamps_t;

    // Moore lamp decode; any unknown phase code shows all red so the
    // one-lamp-per-direction invariant holds even while recovering.
    function automatic lamps_t decode_lamps(input logic [2:0] phase);
        lamps_t l;
        l = '{ns_red: 1'b1, ns_yellow: 1'b0, ns_green: 1'b0,
              ew_red: 1'b1, ew_yellow: 1'b0, ew_green: 1'b0, walk: 1'b0};
        case (phase)
            NS_G: begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
            NS_Y: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
            EW_G: begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
            EW_Y: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
            PED:  l.walk = 1'b1;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter: synchronous clear, tick-enabled increment, saturating at MAX_COUNT.
module phase_timer #(
    parameter int CW        = 5,
    parameter int MAX_COUNT = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && count != MAX_C) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-way intersection controller with min/max green, yellow, all-red clearance and a pedestrian phase.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW    = DEF_YELLOW,
    parameter int ALL_RED   = DEF_ALL_RED,
    parameter int WALK      = DEF_WALK,
    parameter int CW        = DEF_CW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CW:0] MIN_T  = (CW+1)'(MIN_GREEN);
    localparam logic [CW:0] MAX_T  = (CW+1)'(MAX_GREEN);
    localparam logic [CW:0] YEL_T  = (CW+1)'(YELLOW);
    localparam logic [CW:0] AR_T   = (CW+1)'(ALL_RED);
    localparam logic [CW:0] WALK_T = (CW+1)'(WALK);

    logic [CW-1:0] timer;
    logic [CW:0]   t_next;
    logic [2:0]    next_phase;
    logic          timer_clear;
    logic          ped_pending;
    dir_t          last_green;
    lamps_t        lamps;

    phase_timer #(
        .CW        (CW),
        .MAX_COUNT (MAX_GREEN)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick),
        .count (timer)
    );

    // One extra bit so t' stays exact when the timer sits saturated at MAX_GREEN.
    assign t_next = {1'b0, timer} + (CW+1)'(1);

    function automatic logic green_done(input logic [CW:0] t, input logic own_car,
                                        input logic demand);
        return demand && ((t >= MIN_T && !own_car) || t >= MAX_T);
    endfunction

    always_comb begin
        next_phase = phase;
        case (phase)
            NS_G:  if (tick && green_done(t_next, ns_car, ew_car | ped_pending)) next_phase = NS_Y;
            NS_Y:  if (tick && t_next == YEL_T) next_phase = AR_NS;
            AR_NS: if (tick && t_next == AR_T)  next_phase = ped_pending ? PED : EW_G;
            EW_G:  if (tick && green_done(t_next, ew_car, ns_car | ped_pending)) next_phase = EW_Y;
            EW_Y:  if (tick && t_next == YEL_T) next_phase = AR_EW;
            AR_EW: if (tick && t_next == AR_T)  next_phase = ped_pending ? PED : NS_G;
            PED:   if (tick && t_next == WALK_T)
                       next_phase = (last_green == DIR_NS) ? EW_G : NS_G;
            default: next_phase = NS_G;
        endcase
    end

    assign timer_clear = (next_phase != phase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= NS_G;
            ped_pending <= 1'b0;
            last_green  <= DIR_NS;
        end else begin
            phase <= next_phase;
            // A press on the PED entry edge belongs to the next walk cycle.
            if (next_phase == PED && phase != PED) begin
                ped_pending <= ped_req;
            end else if (phase != PED && ped_req) begin
                ped_pending <= 1'b1;
            end
            if (next_phase == NS_G) begin
                last_green <= DIR_NS;
            end else if (next_phase == EW_G) begin
                last_green <= DIR_EW;
            end
        end
    end

    assign lamps     = decode_lamps(phase);
    assign ns_red    = lamps.ns_red;
    assign ns_yellow = lamps.ns_yellow;
    assign ns_green  = lamps.ns_green;
    assign ew_red    = lamps.ew_red;
    assign ew_yellow = lamps.ew_yellow;
    assign ew_green  = lamps.ew_green;
    assign walk      = lamps.walk;

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameter MIN_GREEN, 8, minimum green duration in ticks (>=1).
REQ-002 Parameter MAX_GREEN, 20, maximum green duration under contention, in ticks (>=MIN_GREEN, <2^CW).
REQ-003 Parameter YELLOW, 3, yellow duration in ticks (>=1).
REQ-004 Parameter ALL_RED, 2, all-red clearance duration in ticks (>=1).
REQ-005 Parameter WALK, 6, pedestrian walk duration in ticks (>=1).
REQ-006 Parameter CW, 5, phase-timer width in bits.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 tick  in  1  time-base enable, one-cycle pulse per time unit.
REQ-010 ns_car  in  1  level: vehicle waiting on the NS approach.
REQ-011 ew_car  in  1  level: vehicle waiting on the EW approach.
REQ-012 ped_req  in  1  pedestrian button, sampled every clk.
REQ-013 ns_red, ns_yellow, ns_green  out  1 each  NS lamp drives.
REQ-014 ew_red, ew_yellow, ew_green  out  1 each  EW lamp drives.
REQ-015 walk  out  1  pedestrian walk lamp.
REQ-016 phase  out  3  current phase code.

Function
REQ-017 Phases SHALL be NS_G=0, NS_Y=1, AR_NS=2, EW_G=3, EW_Y=4, AR_EW=5, PED=6; code 7 is illegal and SHALL recover to NS_G on the next clk.
REQ-018 Phase timer SHALL clear on every phase entry, increment on each tick, and saturate at MAX_GREEN; t' denotes timer+1 on a tick cycle.
REQ-019 Transitions SHALL occur only on tick cycles; with tick low, phase, timer and lamps SHALL hold.
REQ-020 Green exit (NS_G->NS_Y, EW_G->EW_Y): demand = opposing car OR ped_pending; exit when (t'>=MIN_GREEN AND demand AND own car low) OR (t'>=MAX_GREEN AND demand).
REQ-021 With no demand, green SHALL rest indefinitely.
REQ-022 NS_Y->AR_NS and EW_Y->AR_EW when t'==YELLOW.
REQ-023 All-red exit when t'==ALL_RED: to PED if ped_pending, else to the opposing green (AR_NS->EW_G, AR_EW->NS_G).
REQ-024 PED exit when t'==WALK, to the green opposite the direction that last held green.
REQ-025 ped_pending SHALL set on ped_req in any phase except PED and clear on the entry edge into PED; a ped_req on that entry cycle SHALL remain pending.
REQ-026 Lamps SHALL be a Moore decode of phase, updating on the same edge as phase: green/yellow lit only in own G/Y phase, red otherwise; walk=1 only in PED.
REQ-027 Each direction SHALL light exactly one lamp at all times; NS and EW SHALL never be simultaneously non-red.

Reset
REQ-028 reset SHALL force immediately: phase=NS_G, timer=0, ped_pending=0, last-green=NS; ns_green=1, ew_red=1, walk=0, all other lamps 0.
REQ-029 reset asserted mid-phase SHALL abandon the phase with no yellow or clearance; the first tick after release counts as t'=1 in NS_G.

Structure
REQ-030 Phase codes and default duration constants SHALL live in package intersection_pkg.
REQ-031 The timer SHALL be sub-module phase_timer (clear, tick-enable, saturating count, CW bits).

Verification (default parameters, tick high every cycle unless stated)
REQ-032 Reset, no cars, no ped_req, 50 cycles -> phase=0 throughout, ns_green=1, ew_red=1.
REQ-033 ew_car held high from reset -> NS_Y entered after 8th tick, AR_NS after 3 more, EW_G after 2 more (cycles 8, 11, 13).
REQ-034 ns_car and ew_car both held -> each green lasts exactly 20 ticks, yellow 3, all-red 2, alternating indefinitely.
REQ-035 One-cycle ped_req at cycle 2, no cars -> NS_Y at 8, AR_NS at 11, PED (walk=1, all red) at 13, EW_G at 19, ped_pending=0 after 13.
REQ-036 tick low for 10 cycles inside NS_Y -> phase and lamps frozen; reset pulsed mid-EW_Y -> ns_green=1 and ped_pending=0 before the next clk edge.
REQ-037 Continuous checker on every run: REQ-027 invariants hold, phase never 7 for more than one cycle.
